// File: rtl/expr_tx.sv
// Expression transmitter: buffers tokens, sends them as ASCII followed by '=', then captures and checks the result.
// Optional WAIT timeout is enabled by defining EXPR_TX_TIMEOUT_EN.
module expr_tx #(
  parameter int MAX_TOK = 15,
  parameter int TIMEOUT = 255
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tok_we,
  input  logic [4:0] tok_data,
  input  logic       tok_clr,
  input  logic       start,
  input  logic [6:0] exp_result,
  output logic [7:0] ascii_out,
  output logic       ready,
  input  logic       valid,
  input  logic [6:0] result,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic       err,
  output logic [6:0] got_result
);

  localparam int CW = $clog2(MAX_TOK + 1);
  localparam logic [CW-1:0] MAX_C = CW'(MAX_TOK);

  typedef enum logic [2:0] {IDLE, SEND, SEND_EQ, WAIT, FIN} state_t;

  state_t        state, state_nxt;
  logic [4:0]    tok_buf [MAX_TOK];
  logic [CW-1:0] count, idx;
  logic [6:0]    exp_q;
  logic          timeout_hit;
  logic          tok_bad;
  logic          start_ok;

  function automatic logic [7:0] enc(input logic [4:0] t);
    logic [7:0] c;
    if (!t[4]) begin
      c = (t[3:0] < 4'd10) ? (8'h30 + {4'd0, t[3:0]}) : (8'h57 + {4'd0, t[3:0]});
    end else begin
      case (t[2:0])
        3'd0:    c = 8'h28;
        3'd1:    c = 8'h29;
        3'd2:    c = 8'h2A;
        3'd3:    c = 8'h2B;
        3'd4:    c = 8'h2D;
        default: c = 8'h3F;
      endcase
    end
    return c;
  endfunction

`ifdef EXPR_TX_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] tmr;

  // Loaded while '=' goes out so the terminal count lands TIMEOUT cycles after it.
  always_ff @(posedge clk) begin
    if (rst)                              tmr <= '0;
    else if (state == SEND_EQ)            tmr <= TW'(TIMEOUT - 1);
    else if (state == WAIT && tmr != '0)  tmr <= tmr - 1'b1;
  end
  assign timeout_hit = (state == WAIT) && (tmr <= TW'(1));
`else
  assign timeout_hit = 1'b0;
`endif

  assign tok_bad  = (count == MAX_C) || (tok_data[4] && tok_data[2:0] > 3'd4);
  assign start_ok = (state == IDLE) && start && (count != '0);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start_ok) state_nxt = SEND;
      SEND:    if (idx == CW'(count - 1'b1)) state_nxt = SEND_EQ;
      SEND_EQ: state_nxt = WAIT;
      WAIT:    if (valid || timeout_hit) state_nxt = FIN;
      FIN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    ascii_out = 8'h00;
    ready     = 1'b0;
    case (state)
      SEND: begin
        ascii_out = enc(tok_buf[idx]);
        ready     = 1'b1;
      end
      SEND_EQ: begin
        ascii_out = 8'h3D;
        ready     = 1'b1;
      end
      default: ;
    endcase
    busy = (state == SEND) || (state == SEND_EQ) || (state == WAIT);
    done = (state == FIN);
  end

  // Token storage carries no reset; count alone defines what is valid.
  always_ff @(posedge clk) begin
    if (state == IDLE && !tok_clr && tok_we && !tok_bad)
      tok_buf[count] <= tok_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count      <= '0;
      idx        <= '0;
      exp_q      <= '0;
      pass       <= 1'b0;
      err        <= 1'b0;
      got_result <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (tok_clr) begin
            count <= '0;
            err   <= 1'b0;
          end else if (tok_we) begin
            if (tok_bad) err <= 1'b1;
            else         count <= count + 1'b1;
          end
          if (start) begin
            if (count == '0) begin
              err <= 1'b1;
            end else begin
              idx   <= '0;
              exp_q <= exp_result;
            end
          end
        end
        SEND: idx <= idx + 1'b1;
        WAIT: begin
          if (valid) begin
            got_result <= result;
            pass       <= (result == exp_q);
          end else if (timeout_hit) begin
            got_result <= '0;
            pass       <= 1'b0;
            err        <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_expr_tx.sv
// Directed, table-driven bench for expr_tx: frame contents, result capture, error and reset corners.
module tb_expr_tx;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tok_we = 1'b0;
  logic [4:0] tok_data = '0;
  logic       tok_clr = 1'b0;
  logic       start = 1'b0;
  logic [6:0] exp_result = '0;
  logic [7:0] ascii_out;
  logic       ready;
  logic       valid = 1'b0;
  logic [6:0] result = '0;
  logic       busy, done, pass, err;
  logic [6:0] got_result;

  int n_pass = 0;
  int n_total = 0;

  logic [7:0] exp_chars [16];

  expr_tx #(.MAX_TOK(15), .TIMEOUT(8)) dut (
    .clk(clk), .rst(rst), .tok_we(tok_we), .tok_data(tok_data), .tok_clr(tok_clr),
    .start(start), .exp_result(exp_result), .ascii_out(ascii_out), .ready(ready),
    .valid(valid), .result(result), .busy(busy), .done(done), .pass(pass),
    .err(err), .got_result(got_result)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          n;
    logic [39:0] toks;
    logic [71:0] chrs;
    logic [6:0]  exp_res;
    logic [6:0]  res;
    logic        exp_pass;
  } vec_t;

  vec_t vecs [4];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_total++;
    if (act !== expv) $display("FAIL %s: got %0h expected %0h", nm, act, expv);
    else n_pass++;
  endtask

  task automatic write_tok(input logic [4:0] t);
    tok_we = 1'b1;
    tok_data = t;
    tick();
    tok_we = 1'b0;
  endtask

  task automatic clear_buf();
    tok_clr = 1'b1;
    tick();
    tok_clr = 1'b0;
  endtask

  // Starts a frame and checks n characters (including '='); optionally pulses start mid-frame.
  task automatic send_check(input int n, input int restart_at, input logic [6:0] expv);
    exp_result = expv;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < n; i++) begin
      chk($sformatf("ready[%0d]", i), ready, 1);
      chk($sformatf("char[%0d]", i), ascii_out, exp_chars[i]);
      if (i == restart_at) start = 1'b1;
      tick();
      start = 1'b0;
    end
    chk("ready_after_eq", ready, 0);
    chk("busy_in_wait", busy, 1);
  endtask

  task automatic give_result(input logic [6:0] r, input logic exp_p);
    valid = 1'b1;
    result = r;
    tick();
    valid = 1'b0;
    chk("done_pulse", done, 1);
    chk("pass", pass, exp_p);
    chk("got_result", got_result, r);
    chk("busy_fin", busy, 0);
    tick();
    chk("done_one_cycle", done, 0);
  endtask

  initial begin
    vecs[0] = '{5, {5'h03, 5'h13, 5'h04, 5'h12, 5'h02, 15'd0},
                {8'h33, 8'h2B, 8'h34, 8'h2A, 8'h32, 8'h3D, 24'd0}, 7'd11, 7'd11, 1'b1};
    vecs[1] = '{7, {5'h0A, 5'h14, 5'h10, 5'h05, 5'h13, 5'h01, 5'h11, 5'd0},
                {8'h61, 8'h2D, 8'h28, 8'h35, 8'h2B, 8'h31, 8'h29, 8'h3D, 8'd0}, 7'd4, 7'd3, 1'b0};
    vecs[2] = '{3, {5'h0F, 5'h14, 5'h09, 25'd0},
                {8'h66, 8'h2D, 8'h39, 8'h3D, 40'd0}, 7'd6, 7'd6, 1'b1};
    vecs[3] = '{3, {5'h00, 5'h11, 5'h12, 25'd0},
                {8'h30, 8'h29, 8'h2A, 8'h3D, 40'd0}, 7'd0, 7'd127, 1'b0};

    tick();
    tick();
    rst = 1'b0;
    chk("rst_ascii", ascii_out, 0);
    chk("rst_ready", ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_pass", pass, 0);
    chk("rst_err", err, 0);
    chk("rst_got", got_result, 0);

    // valid outside WAIT has no effect
    valid = 1'b1;
    result = 7'd5;
    tick();
    valid = 1'b0;
    chk("idle_valid_done", done, 0);
    chk("idle_valid_got", got_result, 0);

    for (int v = 0; v < 4; v++) begin
      clear_buf();
      for (int k = 0; k < vecs[v].n; k++) write_tok(vecs[v].toks[39 - 5*k -: 5]);
      chk("load_err", err, 0);
      for (int k = 0; k <= vecs[v].n; k++) exp_chars[k] = vecs[v].chrs[71 - 8*k -: 8];
      send_check(vecs[v].n + 1, -1, vecs[v].exp_res);
      tick();
      chk("wait_hold_busy", busy, 1);
      chk("wait_hold_done", done, 0);
      give_result(vecs[v].res, vecs[v].exp_pass);
    end

    // Buffer retained: resend last expression unchanged, check against a different expected value
    send_check(4, -1, 7'd127);
    give_result(7'd127, 1'b1);

    // Start during SEND is ignored
    clear_buf();
    for (int k = 0; k < vecs[0].n; k++) write_tok(vecs[0].toks[39 - 5*k -: 5]);
    for (int k = 0; k <= vecs[0].n; k++) exp_chars[k] = vecs[0].chrs[71 - 8*k -: 8];
    send_check(6, 1, 7'd11);
    give_result(7'd11, 1'b1);

    // Overflow: 16th token dropped, 15 chars then '='
    clear_buf();
    for (int k = 0; k < 16; k++) write_tok(5'(k % 10));
    chk("ovf_err", err, 1);
    for (int k = 0; k < 15; k++) exp_chars[k] = 8'h30 + 8'(k % 10);
    exp_chars[15] = 8'h3D;
    send_check(16, -1, 7'd1);
    give_result(7'd2, 1'b0);
    chk("ovf_err_sticky", err, 1);

    // Bad operator code, then tok_clr clears err
    clear_buf();
    chk("clr_err", err, 0);
    write_tok(5'h15);
    chk("badop_err", err, 1);
    clear_buf();
    chk("badop_clr", err, 0);

    // Empty start
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("empty_ready", ready, 0);
    chk("empty_busy", busy, 0);
    chk("empty_err", err, 1);

    // Reset at the 3rd character
    clear_buf();
    for (int k = 0; k < vecs[0].n; k++) write_tok(vecs[0].toks[39 - 5*k -: 5]);
    exp_result = 7'd11;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    chk("third_char", ascii_out, 8'h34);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rstsend_ready", ready, 0);
    chk("rstsend_busy", busy, 0);
    chk("rstsend_ascii", ascii_out, 0);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("rstsend_count0_ready", ready, 0);
    chk("rstsend_count0_err", err, 1);

    // Reset mid-WAIT
    clear_buf();
    write_tok(5'h07);
    exp_chars[0] = 8'h37;
    exp_chars[1] = 8'h3D;
    send_check(2, -1, 7'd7);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rstwait_busy", busy, 0);
    valid = 1'b1;
    result = 7'd7;
    tick();
    valid = 1'b0;
    chk("rstwait_done", done, 0);
    chk("rstwait_got", got_result, 0);

    // WAIT behaviour without a result
    clear_buf();
    for (int k = 0; k < vecs[0].n; k++) write_tok(vecs[0].toks[39 - 5*k -: 5]);
    for (int k = 0; k <= vecs[0].n; k++) exp_chars[k] = vecs[0].chrs[71 - 8*k -: 8];
    send_check(6, -1, 7'd11);
`ifdef EXPR_TX_TIMEOUT_EN
    for (int c = 2; c <= 7; c++) begin
      tick();
      chk($sformatf("to_nodone_%0d", c), done, 0);
    end
    tick();
    chk("to_done", done, 1);
    chk("to_err", err, 1);
    chk("to_pass", pass, 0);
    chk("to_got", got_result, 0);
    tick();
    chk("to_done_one_cycle", done, 0);
`else
    for (int c = 0; c < 20; c++) tick();
    chk("nto_busy", busy, 1);
    chk("nto_done", done, 0);
    give_result(7'd11, 1'b1);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/expr_tx.md
EXPR_TX -- requirements
Module: expr_tx

Interface
REQ-001 Parameter MAX_TOK, default 15: token buffer depth; one slot is reserved for the '=' terminator within the 16-char frame.
REQ-002 Parameter TIMEOUT, default 255: maximum number of WAIT cycles for a result (used only under REQ-026).
REQ-003 clk  input  1  single clock; all logic is on the rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 tok_we  input  1  token write strobe.
REQ-006 tok_data  input  5  token: bit4=0 is an operand with value [3:0]; bit4=1 is an operator code [2:0] (0 '(', 1 ')', 2 '*', 3 '+', 4 '-').
REQ-007 tok_clr  input  1  clears the token buffer.
REQ-008 start  input  1  begins transmission of the buffered expression.
REQ-009 exp_result  input  7  expected result, latched at start.
REQ-010 ascii_out  output  8  ASCII character to the calculator.
REQ-011 ready  output  1  ascii_out is valid this cycle.
REQ-012 valid  input  1  calculator result strobe.
REQ-013 result  input  7  calculator result.
REQ-014 busy, done, pass, err  output  1 each  status flags; got_result  output  7  captured result.

Function
REQ-015 States SHALL be IDLE, SEND, SEND_EQ, WAIT and FIN.
- IDLE -> SEND on start with count>0.
- SEND -> SEND_EQ after the last token is sent.
- SEND_EQ -> WAIT after one cycle.
- WAIT -> FIN on valid.
- FIN -> IDLE after one cycle.
REQ-016 In IDLE, tok_we SHALL write tok_data to slot count and increment count; tok_clr SHALL set count=0 and clear err; tok_clr takes priority over tok_we in the same cycle.
REQ-017 tok_we with count==MAX_TOK, or with an operator code of 5-7, SHALL be dropped and SHALL set err (sticky).
REQ-018 When start is sampled high in IDLE in cycle N, token k SHALL appear on ascii_out with ready=1 in cycle N+1+k, '=' (0x3D) in cycle N+1+count, and ready=0 in every other cycle.
REQ-019 Operand encoding: values 0-9 map to 0x30+v; values 10-15 map to 0x61+(v-10). Operator encoding: '(' 0x28, ')' 0x29, '*' 0x2A, '+' 0x2B, '-' 0x2D.
REQ-020 In WAIT, the first cycle with valid=1 SHALL latch got_result=result and pass=(result==exp_result latched); done SHALL pulse high for exactly the following cycle (FIN).
REQ-021 valid SHALL be ignored outside WAIT.
REQ-022 start SHALL be ignored when busy=1. start with count==0 SHALL be ignored and SHALL set err.
REQ-023 busy SHALL be 1 in SEND, SEND_EQ and WAIT, and 0 otherwise. tok_we and tok_clr SHALL be ignored while busy.
REQ-024 The token buffer and count SHALL be retained after FIN, so a repeated start resends the same expression.

Reset
REQ-025 rst=1 SHALL abort any state, go to IDLE, and clear count, ascii_out, ready, busy, done, pass, err and got_result to 0 in the next cycle, including mid-SEND and mid-WAIT.

Configuration
REQ-026 With EXPR_TX_TIMEOUT_EN defined, WAIT SHALL count cycles; reaching TIMEOUT without valid SHALL go to FIN with err=1, pass=0, got_result=0, and done pulsing. Without the macro, WAIT SHALL persist until valid or rst; no counter is present.

Verification
REQ-027 Load 3,'+',4,'*',2; start; exp=11 -> ascii_out '3','+','4','*','2','=' on 6 consecutive ready cycles; valid with result=11 -> pass=1, done high for one cycle.
REQ-028 Load 'a','-','(',5,'+',1,')'; exp=4; result=3 -> chars 0x61,0x2D,0x28,0x35,0x2B,0x31,0x29,0x3D; pass=0, got_result=3.
REQ-029 Write 16 tokens -> 16th dropped, err=1, count=15; start -> 15 characters plus '='.
REQ-030 start with empty buffer, and start during SEND -> ignored, ready stays 0 or the frame is unchanged; err=1 for the empty case.
REQ-031 rst asserted at the 3rd character -> next cycle ready=0, busy=0, count=0; a subsequent start is ignored with err=1.
REQ-032 With EXPR_TX_TIMEOUT_EN and TIMEOUT=8, no valid -> done fires 8 cycles after '=', with err=1 and pass=0.
